// File: rtl/core_mem_pkg.sv
// Shared definitions for the memory-port arbiter: funct3 codes, arbiter
// state encoding and bus geometry.
package core_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DATA_WAIT  = 2'd1,
    ST_FETCH_WAIT = 2'd2
  } arb_state_e;

  // Encodings with no load/store meaning in RV32.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Shared memory bus: request/write channel from the arbiter, ack/read data
// back from the memory side.
interface mem_port_arb_if;
  logic                              bus_req;
  logic                              bus_we;
  logic [core_mem_pkg::XLEN-1:0]     bus_addr;
  logic [core_mem_pkg::XLEN-1:0]     bus_wdata;
  logic [core_mem_pkg::BE_W-1:0]     bus_be;
  logic                              bus_ack;
  logic [core_mem_pkg::XLEN-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_port_arb_lsu_align.sv
// Combinational load/store alignment: store byte-lane placement, load
// byte/half extraction with extension, and misalignment/illegal funct3 check.
module lsu_align
  import core_mem_pkg::*;
(
  input  logic [2:0]                st_f3,
  input  logic [1:0]                st_off,
  input  logic [XLEN-1:0]           st_data,
  input  logic [2:0]                ld_f3,
  input  logic [1:0]                ld_off,
  input  logic [XLEN-1:0]           ld_raw,
  output logic                      fault,
  output logic [BE_W-1:0]           st_be,
  output logic [BE_W-1:0][7:0]      st_lanes,
  output logic [XLEN-1:0]           ld_data
);

  logic            st_is_b, st_is_h, st_is_w;
  logic [BE_W-1:0][7:0] raw_b;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign st_is_b = (st_f3[1:0] == 2'b00);
  assign st_is_h = (st_f3[1:0] == 2'b01);
  assign st_is_w = (st_f3[1:0] == 2'b10);

  assign fault = f3_illegal(st_f3) | (st_is_h & st_off[0]) | (st_is_w & (|st_off));

  // Narrow stores replicate across the word so each lane already carries
  // its byte; the enables pick which lanes the memory actually writes.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign st_be[i]    = st_is_b ? (st_off == 2'(i)) :
                         st_is_h ? (st_off[1] == 1'(i / 2)) : 1'b1;
    assign st_lanes[i] = st_is_b ? st_data[7:0] :
                         st_is_h ? st_data[8*(i%2) +: 8] : st_data[8*i +: 8];
  end

  assign raw_b   = ld_raw;
  assign ld_byte = raw_b[ld_off];
  assign ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];

  always_comb begin
    ld_data = ld_raw;
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates the single memory bus between instruction fetch and the MEM
// stage load/store, with a streak limit so fetch cannot starve.
module mem_port_arb
  import core_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             me_mem_read,
  input  logic             me_mem_write,
  input  logic [XLEN-1:0]  me_alu_o,
  input  logic [XLEN-1:0]  me_regs_data2,
  input  logic [2:0]       me_func3_code,
  output logic [XLEN-1:0]  me_rdata,
  output logic             me_done,
  output logic             me_fault,
  output logic             stall_me,
  input  logic             if_req,
  input  logic [XLEN-1:0]  if_addr,
  input  logic             if_flush,
  output logic [XLEN-1:0]  if_rdata,
  output logic             if_done,
  output logic             stall_if,
  mem_port_arb_if.master   bus
);

  arb_state_e            state, state_nxt;
  logic [STREAK_W-1:0]   streak;
  logic                  discard;
  logic [2:0]            acc_f3;
  logic [1:0]            acc_off;

  logic                  mem_acc, fault_cond, dreq, freq, streak_full;
  logic                  grant_f, grant_d;
  logic [BE_W-1:0]       st_be;
  logic [BE_W-1:0][7:0]  st_lanes;
  logic [XLEN-1:0]       ld_data;
  logic                  unused_if_addr;

  // Fetch addresses are word aligned by contract; low bits are dropped.
  assign unused_if_addr = ^if_addr[1:0];

  lsu_align u_align (
    .st_f3    (me_func3_code),
    .st_off   (me_alu_o[1:0]),
    .st_data  (me_regs_data2),
    .ld_f3    (acc_f3),
    .ld_off   (acc_off),
    .ld_raw   (bus.bus_rdata),
    .fault    (fault_cond),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_data  (ld_data)
  );

  assign mem_acc     = me_mem_read | me_mem_write;
  assign dreq        = mem_acc & ~fault_cond;
  assign freq        = if_req & ~if_flush;
  assign streak_full = (streak == STREAK_W'(MAX_DATA_STREAK));

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    me_done   = 1'b0;
    me_fault  = 1'b0;
    if_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        me_fault = mem_acc & fault_cond;
        if (freq && (!dreq || streak_full)) begin
          grant_f   = 1'b1;
          state_nxt = ST_FETCH_WAIT;
        end else if (dreq) begin
          grant_d   = 1'b1;
          state_nxt = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: if (bus.bus_ack) begin
        me_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_FETCH_WAIT: if (bus.bus_ack) begin
        if_done   = ~discard;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign me_rdata = ld_data;
  assign if_rdata = bus.bus_rdata;
  assign stall_me = mem_acc & ~me_done & ~me_fault;
  assign stall_if = if_req & ~if_done & ~if_flush;

  // Bus channel is registered at the grant edge and held until the ack cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      acc_f3        <= '0;
      acc_off       <= '0;
    end else if (grant_f) begin
      bus.bus_req   <= 1'b1;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= {if_addr[XLEN-1:2], 2'b00};
      bus.bus_wdata <= '0;
      bus.bus_be    <= '1;
    end else if (grant_d) begin
      bus.bus_req   <= 1'b1;
      bus.bus_we    <= me_mem_write;
      bus.bus_addr  <= {me_alu_o[XLEN-1:2], 2'b00};
      bus.bus_wdata <= me_mem_write ? st_lanes : '0;
      bus.bus_be    <= me_mem_write ? st_be : '1;
      acc_f3        <= me_func3_code;
      acc_off       <= me_alu_o[1:0];
    end else if (state != ST_IDLE && bus.bus_ack) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
    end
  end

  // Streak only counts data wins that actually kept a fetch waiting.
  always_ff @(posedge clk) begin
    if (!rstn || !freq || grant_f)          streak <= '0;
    else if (grant_d && !streak_full)       streak <= streak + 1'b1;
  end

  // A flushed fetch still has to drain from the bus; its data is dropped.
  always_ff @(posedge clk) begin
    if (!rstn)                                            discard <= 1'b0;
    else if (state == ST_FETCH_WAIT && bus.bus_ack)       discard <= 1'b0;
    else if (state == ST_FETCH_WAIT && if_flush)          discard <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a cycle-level reference model and
// hand-computed checks for the key scenarios.
module tb_mem_port_arb;
  import core_mem_pkg::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        me_mem_read = 1'b0, me_mem_write = 1'b0;
  logic [31:0] me_alu_o = '0, me_regs_data2 = '0;
  logic [2:0]  me_func3_code = '0;
  logic [31:0] me_rdata;
  logic        me_done, me_fault, stall_me;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done, stall_if;

  mem_port_arb_if bif();

  mem_port_arb #(.MAX_DATA_STREAK(MAX), .STREAK_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_func3_code(me_func3_code),
    .me_rdata(me_rdata), .me_done(me_done), .me_fault(me_fault), .stall_me(stall_me),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .stall_if(stall_if),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit live = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus responder ----------------
  int          ack_lat = 1;
  logic [31:0] rsp_data = '0;
  initial begin
    int rcnt;
    rcnt = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bif.bus_req) rcnt++; else rcnt = 0;
      bif.bus_ack   = bif.bus_req && (rcnt >= ack_lat);
      bif.bus_rdata = rsp_data;
    end
  end

  // ---------------- reference model ----------------
  int          m_busy = 0;        // 0 none, 1 data, 2 fetch
  int          m_streak = 0;
  bit          m_disc = 1'b0;
  bit          m_req = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [2:0]  m_f3 = '0;
  int          m_off = 0;

  function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] raw, input logic [2:0] f3, input int off);
    logic [31:0] v;
    v = raw >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = raw;
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit mem_acc, flt, dreq, freq, ack, e_done, e_fault, e_ifd;
    int sz;
    logic [63:0] mask, w;
    mem_acc = me_mem_read | me_mem_write;
    flt     = m_fault(me_func3_code, me_alu_o);
    dreq    = mem_acc && !flt;
    freq    = if_req && !if_flush;
    ack     = bif.bus_ack;
    e_done  = (m_busy == 1) && ack;
    e_ifd   = (m_busy == 2) && ack && !m_disc;
    e_fault = (m_busy == 0) && mem_acc && flt;

    chk("me_done", me_done, e_done);
    chk("me_fault", me_fault, e_fault);
    chk("if_done", if_done, e_ifd);
    chk("stall_me", stall_me, mem_acc && !e_done && !e_fault);
    chk("stall_if", stall_if, if_req && !if_flush && !e_ifd);
    chk("bus_req", bif.bus_req, m_req);
    if (e_done) chk("me_rdata", me_rdata, m_ext(bif.bus_rdata, m_f3, m_off));
    if (e_ifd)  chk("if_rdata", if_rdata, bif.bus_rdata);
    if (m_req) begin
      chk("bus_we", bif.bus_we, m_we);
      chk("bus_addr", bif.bus_addr, m_addr);
      if (m_we) begin
        chk("bus_be", bif.bus_be, m_be);
        chk("bus_wdata", bif.bus_wdata, m_wdata);
      end
    end

    if (!rstn) begin
      m_busy = 0; m_streak = 0; m_disc = 0; m_req = 0; m_we = 0;
    end else begin
      if (m_busy == 0) begin
        if (freq && (!dreq || m_streak == MAX)) begin
          m_busy = 2; m_req = 1; m_we = 0; m_addr = if_addr & ~32'h3; m_streak = 0;
        end else if (dreq) begin
          m_busy = 1; m_req = 1; m_we = me_mem_write;
          m_addr = me_alu_o & ~32'h3;
          m_f3   = me_func3_code;
          m_off  = int'(me_alu_o[1:0]);
          sz     = 1 << me_func3_code[1:0];
          mask   = (64'd1 << (8 * sz)) - 64'd1;
          m_be   = 4'(((1 << sz) - 1) << m_off);
          w      = '0;
          for (int k = 0; k < 4 / sz; k++) w = w | ((64'(me_regs_data2) & mask) << (8 * sz * k));
          m_wdata = w[31:0];
          if (freq && m_streak < MAX) m_streak++;
        end
      end else if (ack) begin
        if (m_busy == 2) m_disc = 0;
        m_busy = 0; m_req = 0; m_we = 0;
      end else if (m_busy == 2 && if_flush) begin
        m_disc = 1;
      end
      if (!freq) m_streak = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (live) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_mem(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [31:0] rdat, input int lat,
                         output logic [31:0] got, output int nreq,
                         output logic [31:0] b_addr, output logic [31:0] b_wdata,
                         output logic [3:0] b_be, output logic b_we);
    bit done;
    tick();
    me_mem_read = !wr; me_mem_write = wr; me_func3_code = f3;
    me_alu_o = addr; me_regs_data2 = wdat; rsp_data = rdat; ack_lat = lat;
    done = 0; nreq = 0; got = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_we = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bif.bus_req) begin
        if (nreq == 0) begin
          b_addr = bif.bus_addr; b_wdata = bif.bus_wdata; b_be = bif.bus_be; b_we = bif.bus_we;
        end
        nreq++;
      end
      if (me_done) begin got = me_rdata; done = 1; end
    end
    chk("run_mem_done_seen", 32'(done), 32'd1);
    tick();
    me_mem_read = 0; me_mem_write = 0;
  endtask

  initial begin
    logic [31:0] got, ba, bw, a, d;
    logic [3:0]  bb;
    logic        bwe;
    int          nreq, n;
    bit          seen;
    logic [5:0]  pat;

    // Reset
    tick(); tick();
    live = 1'b1;
    @(negedge clk);
    chk("rst_bus_req", bif.bus_req, 0);
    chk("rst_bus_we", bif.bus_we, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_bus_wdata", bif.bus_wdata, 0);
    chk("rst_bus_be", bif.bus_be, 0);
    chk("rst_stall_me", stall_me, 0);
    tick(); rstn = 1'b1;

    // LB sign-extend from the top byte, three bus cycles
    run_mem(0, F3_B, 32'h103, 0, 32'h80FF_FF7F, 3, got, nreq, ba, bw, bb, bwe);
    chk("lb_req_cycles", nreq, 3);
    chk("lb_rdata", got, 32'hFFFF_FF80);
    chk("lb_addr", ba, 32'h100);

    // SH to upper half
    run_mem(1, F3_H, 32'h202, 32'h1234_ABCD, 0, 1, got, nreq, ba, bw, bb, bwe);
    chk("sh_addr", ba, 32'h200);
    chk("sh_be", 32'(bb), 32'hC);
    chk("sh_wdata", bw, 32'hABCD_ABCD);
    chk("sh_we", 32'(bwe), 1);

    // SB to lane 1
    run_mem(1, F3_B, 32'h301, 32'h0000_0055, 0, 2, got, nreq, ba, bw, bb, bwe);
    chk("sb_be", 32'(bb), 32'h2);
    chk("sb_wdata", bw, 32'h5555_5555);

    // LH / LHU extension
    run_mem(0, F3_H, 32'h100, 0, 32'h1234_8000, 2, got, nreq, ba, bw, bb, bwe);
    chk("lh_rdata", got, 32'hFFFF_8000);
    run_mem(0, F3_HU, 32'h102, 0, 32'h8001_7FFF, 1, got, nreq, ba, bw, bb, bwe);
    chk("lhu_rdata", got, 32'h0000_8001);

    // Misaligned LW faults without touching the bus
    tick();
    me_mem_read = 1; me_func3_code = F3_W; me_alu_o = 32'h101;
    @(negedge clk);
    chk("lw_mis_fault", me_fault, 1);
    chk("lw_mis_stall", stall_me, 0);
    chk("lw_mis_req", bif.bus_req, 0);
    tick(); me_mem_read = 0;
    @(negedge clk);
    chk("lw_mis_req_after", bif.bus_req, 0);

    // Streak: continuous data with a waiting fetch
    tick();
    me_mem_read = 1; me_func3_code = F3_W; me_alu_o = 32'h40; rsp_data = 32'h0000_0013;
    if_req = 1; if_addr = 32'h1000; ack_lat = 1;
    n = 0; pat = '0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bif.bus_req && bif.bus_ack) begin
        pat[n] = (bif.bus_addr == 32'h1000);
        n++;
      end
    end
    chk("streak_count", n, 6);
    chk("streak_pattern", 32'(pat), 32'b01_0000);
    tick(); me_mem_read = 0; if_req = 0;

    // Flush during FETCH_WAIT
    tick();
    if_req = 1; if_addr = 32'h2000; ack_lat = 3; rsp_data = 32'h0000_0013;
    tick(); if_flush = 1; if_addr = 32'h3000;
    tick(); if_flush = 0;
    seen = 0; d = '1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bif.bus_ack) begin seen = 1; d = 32'(if_done); end
    end
    chk("flush_ack_seen", 32'(seen), 1);
    chk("flush_if_done", d, 0);
    rsp_data = 32'h00A0_0093; ack_lat = 1;
    seen = 0; a = '0; d = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (if_done) begin seen = 1; a = bif.bus_addr; d = if_rdata; end
    end
    chk("refetch_done", 32'(seen), 1);
    chk("refetch_addr", a, 32'h3000);
    chk("refetch_rdata", d, 32'h00A0_0093);
    tick(); if_req = 0;

    // Reset while in DATA_WAIT
    tick();
    me_mem_read = 1; me_func3_code = F3_W; me_alu_o = 32'h80; rsp_data = 32'hCAFE_F00D; ack_lat = 5;
    tick(); rstn = 0;
    tick(); rstn = 1; ack_lat = 2;
    @(negedge clk);
    chk("rst_mid_req", bif.bus_req, 0);
    chk("rst_mid_stall", stall_me, 1);
    seen = 0; got = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (me_done) begin seen = 1; got = me_rdata; end
    end
    chk("rst_mid_redone", 32'(seen), 1);
    chk("rst_mid_rdata", got, 32'hCAFE_F00D);
    tick(); me_mem_read = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
